// File: rtl/hist_lut_gen.sv
// Histogram-equalisation LUT generator: walks a 256-bin CDF and writes an 8-bit LUT,
// sequencing external fixed2float, divider, multiplier and float2fixed cores.
//
// state      | meaning
// FLUSH      | post-reset hold-off, lets stale IP results drain
// IDLE       | waiting for start
// DEN_F2F    | den = total_pixels - cdf_min converted to float
// SCALE_DIV  | scale = 255.0 / denf
// RD_CDF     | read cdf[bin] (address cycle, then data cycle)
// BIN_F2F    | num converted to float
// BIN_MULT   | num_f * scale
// BIN_F2X    | product converted back to fixed
// WR_LUT     | write saturated value to lut[bin]
// DONE       | one-cycle completion pulse

module hist_lut_gen #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_FLUSH      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic [C_DATA_WIDTH-1:0] total_pixels,
    input  logic [C_DATA_WIDTH-1:0] cdf_min,
    output logic                    cdf_rd_en,
    output logic [7:0]              cdf_addr,
    input  logic [C_DATA_WIDTH-1:0] cdf_data,
    output logic                    lut_we,
    output logic [7:0]              lut_addr,
    output logic [7:0]              lut_data,
    output logic [C_DATA_WIDTH-1:0] f2f_a,
    output logic                    f2f_valid,
    input  logic                    f2f_rfd,
    input  logic [C_DATA_WIDTH-1:0] f2f_result,
    input  logic                    f2f_rdy,
    output logic [C_DATA_WIDTH-1:0] div_a,
    output logic [C_DATA_WIDTH-1:0] div_b,
    output logic                    div_valid,
    input  logic                    div_rfd,
    input  logic [C_DATA_WIDTH-1:0] div_result,
    input  logic                    div_rdy,
    output logic [C_DATA_WIDTH-1:0] mult_a,
    output logic [C_DATA_WIDTH-1:0] mult_b,
    output logic                    mult_valid,
    input  logic                    mult_rfd,
    input  logic [C_DATA_WIDTH-1:0] mult_result,
    input  logic                    mult_rdy,
    output logic [C_DATA_WIDTH-1:0] f2x_a,
    output logic                    f2x_valid,
    input  logic                    f2x_rfd,
    input  logic [C_DATA_WIDTH-1:0] f2x_result,
    input  logic                    f2x_rdy
);

    localparam int FLUSH_W = (C_FLUSH > 1) ? $clog2(C_FLUSH) : 1;
    localparam logic [FLUSH_W-1:0]      FLUSH_LAST = FLUSH_W'(C_FLUSH - 1);
    localparam logic [C_DATA_WIDTH-1:0] SCALE_NUM  = C_DATA_WIDTH'(32'h437F_0000);

    typedef enum logic [3:0] {
        ST_FLUSH, ST_IDLE, ST_DEN_F2F, ST_SCALE_DIV, ST_RD_CDF,
        ST_BIN_F2F, ST_BIN_MULT, ST_BIN_F2X, ST_WR_LUT, ST_DONE
    } state_t;

    state_t                  r_state;
    logic [FLUSH_W-1:0]      r_flush_cnt;
    logic [7:0]              r_bin;
    logic                    r_issued;
    logic                    r_rd_ph;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_cdf_rd_en;
    logic [7:0]              r_cdf_addr;
    logic                    r_lut_we;
    logic [7:0]              r_lut_addr;
    logic [7:0]              r_lut_data;
    logic [C_DATA_WIDTH-1:0] r_cdf_min;
    logic [C_DATA_WIDTH-1:0] r_scale;
    logic [C_DATA_WIDTH-1:0] r_f2f_a;
    logic                    r_f2f_valid;
    logic [C_DATA_WIDTH-1:0] r_div_a;
    logic [C_DATA_WIDTH-1:0] r_div_b;
    logic                    r_div_valid;
    logic [C_DATA_WIDTH-1:0] r_mult_a;
    logic [C_DATA_WIDTH-1:0] r_mult_b;
    logic                    r_mult_valid;
    logic [C_DATA_WIDTH-1:0] r_f2x_a;
    logic                    r_f2x_valid;

    logic [C_DATA_WIDTH-1:0] w_num;
    logic [7:0]              w_f2x_sat;

    assign w_num     = (cdf_data > r_cdf_min) ? (cdf_data - r_cdf_min) : '0;
    // Negative fixed-point results clamp to 0, anything above 255 to 255.
    assign w_f2x_sat = f2x_result[C_DATA_WIDTH-1]            ? 8'h00 :
                       (f2x_result > C_DATA_WIDTH'(255))     ? 8'hFF : f2x_result[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_FLUSH;
            r_flush_cnt  <= '0;
            r_bin        <= '0;
            r_issued     <= 1'b0;
            r_rd_ph      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cdf_rd_en  <= 1'b0;
            r_cdf_addr   <= '0;
            r_lut_we     <= 1'b0;
            r_lut_addr   <= '0;
            r_lut_data   <= '0;
            r_cdf_min    <= '0;
            r_scale      <= '0;
            r_f2f_a      <= '0;
            r_f2f_valid  <= 1'b0;
            r_div_a      <= '0;
            r_div_b      <= '0;
            r_div_valid  <= 1'b0;
            r_mult_a     <= '0;
            r_mult_b     <= '0;
            r_mult_valid <= 1'b0;
            r_f2x_a      <= '0;
            r_f2x_valid  <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_cdf_rd_en  <= 1'b0;
            r_lut_we     <= 1'b0;
            r_f2f_valid  <= 1'b0;
            r_div_valid  <= 1'b0;
            r_mult_valid <= 1'b0;
            r_f2x_valid  <= 1'b0;

            case (r_state)
                ST_FLUSH: begin
                    if (r_flush_cnt == FLUSH_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        r_busy    <= 1'b1;
                        r_cdf_min <= cdf_min;
                        r_bin     <= '0;
                        r_issued  <= 1'b0;
                        if (total_pixels <= cdf_min) begin
                            r_scale     <= '0;
                            r_cdf_rd_en <= 1'b1;
                            r_cdf_addr  <= '0;
                            r_rd_ph     <= 1'b0;
                            r_state     <= ST_RD_CDF;
                        end else begin
                            r_f2f_a <= total_pixels - cdf_min;
                            r_state <= ST_DEN_F2F;
                        end
                    end
                end
                ST_DEN_F2F: begin
                    if (!r_issued) begin
                        if (f2f_rfd) begin
                            r_f2f_valid <= 1'b1;
                            r_issued    <= 1'b1;
                        end
                    end else if (f2f_rdy) begin
                        r_div_a  <= SCALE_NUM;
                        r_div_b  <= f2f_result;
                        r_issued <= 1'b0;
                        r_state  <= ST_SCALE_DIV;
                    end
                end
                ST_SCALE_DIV: begin
                    if (!r_issued) begin
                        if (div_rfd) begin
                            r_div_valid <= 1'b1;
                            r_issued    <= 1'b1;
                        end
                    end else if (div_rdy) begin
                        r_scale     <= div_result;
                        r_issued    <= 1'b0;
                        r_bin       <= '0;
                        r_cdf_rd_en <= 1'b1;
                        r_cdf_addr  <= '0;
                        r_rd_ph     <= 1'b0;
                        r_state     <= ST_RD_CDF;
                    end
                end
                ST_RD_CDF: begin
                    // Phase 0 is the address cycle; RAM data is valid in phase 1.
                    if (!r_rd_ph) begin
                        r_rd_ph <= 1'b1;
                    end else begin
                        r_rd_ph  <= 1'b0;
                        r_f2f_a  <= w_num;
                        r_issued <= 1'b0;
                        r_state  <= ST_BIN_F2F;
                    end
                end
                ST_BIN_F2F: begin
                    if (!r_issued) begin
                        if (f2f_rfd) begin
                            r_f2f_valid <= 1'b1;
                            r_issued    <= 1'b1;
                        end
                    end else if (f2f_rdy) begin
                        r_mult_a <= f2f_result;
                        r_mult_b <= r_scale;
                        r_issued <= 1'b0;
                        r_state  <= ST_BIN_MULT;
                    end
                end
                ST_BIN_MULT: begin
                    if (!r_issued) begin
                        if (mult_rfd) begin
                            r_mult_valid <= 1'b1;
                            r_issued     <= 1'b1;
                        end
                    end else if (mult_rdy) begin
                        r_f2x_a  <= mult_result;
                        r_issued <= 1'b0;
                        r_state  <= ST_BIN_F2X;
                    end
                end
                ST_BIN_F2X: begin
                    if (!r_issued) begin
                        if (f2x_rfd) begin
                            r_f2x_valid <= 1'b1;
                            r_issued    <= 1'b1;
                        end
                    end else if (f2x_rdy) begin
                        r_lut_we   <= 1'b1;
                        r_lut_addr <= r_bin;
                        r_lut_data <= w_f2x_sat;
                        r_issued   <= 1'b0;
                        r_state    <= ST_WR_LUT;
                    end
                end
                ST_WR_LUT: begin
                    if (r_bin == 8'hFF) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_bin       <= r_bin + 8'd1;
                        r_cdf_rd_en <= 1'b1;
                        r_cdf_addr  <= r_bin + 8'd1;
                        r_rd_ph     <= 1'b0;
                        r_state     <= ST_RD_CDF;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_FLUSH;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign cdf_rd_en  = r_cdf_rd_en;
    assign cdf_addr   = r_cdf_addr;
    assign lut_we     = r_lut_we;
    assign lut_addr   = r_lut_addr;
    assign lut_data   = r_lut_data;
    assign f2f_a      = r_f2f_a;
    assign f2f_valid  = r_f2f_valid;
    assign div_a      = r_div_a;
    assign div_b      = r_div_b;
    assign div_valid  = r_div_valid;
    assign mult_a     = r_mult_a;
    assign mult_b     = r_mult_b;
    assign mult_valid = r_mult_valid;
    assign f2x_a      = r_f2x_a;
    assign f2x_valid  = r_f2x_valid;

endmodule

// File: tb/tb_hist_lut_gen.sv
// Bench for hist_lut_gen: float IP and CDF RAM models, a spec-level LUT model,
// and one per-cycle compare process driven from the main sequence.
module tb_hist_lut_gen;

    localparam int LAT_F2F  = 3;
    localparam int LAT_DIV  = 14;
    localparam int LAT_MULT = 4;
    localparam int LAT_F2X  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start = 1'b0;
    logic        busy, done;
    logic [31:0] total_pixels = '0, cdf_min = '0;
    logic        cdf_rd_en;
    logic [7:0]  cdf_addr;
    logic [31:0] cdf_data = '0;
    logic        lut_we;
    logic [7:0]  lut_addr, lut_data;
    logic [31:0] f2f_a, f2f_result = '0;
    logic        f2f_valid, f2f_rfd = 1'b1, f2f_rdy = 1'b0;
    logic [31:0] div_a, div_b, div_result = '0;
    logic        div_valid, div_rfd = 1'b1, div_rdy = 1'b0;
    logic [31:0] mult_a, mult_b, mult_result = '0;
    logic        mult_valid, mult_rfd = 1'b1, mult_rdy = 1'b0;
    logic [31:0] f2x_a, f2x_result = '0;
    logic        f2x_valid, f2x_rfd = 1'b1, f2x_rdy = 1'b0;

    hist_lut_gen #(.C_DATA_WIDTH(32), .C_FLUSH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .total_pixels(total_pixels), .cdf_min(cdf_min),
        .cdf_rd_en(cdf_rd_en), .cdf_addr(cdf_addr), .cdf_data(cdf_data),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
        .f2f_a(f2f_a), .f2f_valid(f2f_valid), .f2f_rfd(f2f_rfd),
        .f2f_result(f2f_result), .f2f_rdy(f2f_rdy),
        .div_a(div_a), .div_b(div_b), .div_valid(div_valid), .div_rfd(div_rfd),
        .div_result(div_result), .div_rdy(div_rdy),
        .mult_a(mult_a), .mult_b(mult_b), .mult_valid(mult_valid), .mult_rfd(mult_rfd),
        .mult_result(mult_result), .mult_rdy(mult_rdy),
        .f2x_a(f2x_a), .f2x_valid(f2x_valid), .f2x_rfd(f2x_rfd),
        .f2x_result(f2x_result), .f2x_rdy(f2x_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] cdf [256];
    logic [7:0]  exp_lut [256];
    int          dut_lut [256];
    int          exp_bin, writes, done_cnt, div_cnt;
    logic        prev_f2f, prev_div, prev_mult, prev_f2x;
    bit          force_en = 1'b0;
    bit          inj_en = 1'b0;
    int          inj_bin = 20;

    // ---------------- float32 helpers via double precision ----------------
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [23:0] m;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        m = {1'b0, d[51:29]} + 24'(d[28]);
        e = d[62:52];
        if (m[23]) e = e + 11'd1;
        return {d[63], 8'(e - 11'd896), m[22:0]};
    endfunction

    function automatic logic [31:0] i2f(input logic [31:0] x);
        longint li;
        li = longint'({32'd0, x});
        return r2f(real'(li));
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) / f2r(b));
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] f2x(input logic [31:0] f);
        real r;
        int  v;
        r = f2r(f);
        if (r >= 0.0) v = $rtoi(r + 0.5);
        else          v = -$rtoi(0.5 - r);
        return 32'(v);
    endfunction

    // Bins 10 and 11 can be forced to out-of-range float2fixed outputs.
    function automatic logic [31:0] forced(input int bin, input logic [31:0] v);
        if (force_en && bin == 10) return 32'h8000_0005;
        if (force_en && bin == 11) return 32'd1000;
        return v;
    endfunction

    // ---------------- spec-level LUT model ----------------
    task automatic build_model(input logic [31:0] tp, input logic [31:0] mn);
        logic [31:0] scale, num, v;
        scale = (tp <= mn) ? 32'd0 : fdiv(32'h437F_0000, i2f(tp - mn));
        for (int i = 0; i < 256; i++) begin
            num = (cdf[i] > mn) ? cdf[i] - mn : 32'd0;
            v = forced(i, f2x(fmul(i2f(num), scale)));
            exp_lut[i] = v[31] ? 8'd0 : (v > 32'd255) ? 8'd255 : v[7:0];
        end
    endtask

    // ---------------- environment models ----------------
    logic        rd_pend = 1'b0;
    logic [7:0]  rd_addr = '0;
    always @(negedge clk) begin
        cdf_data = rd_pend ? cdf[rd_addr] : 32'hBAD0_BAD0;
        rd_pend  = cdf_rd_en;
        rd_addr  = cdf_addr;
    end

    int f2f_cnt = 0, div_cnt_ip = 0, mult_cnt = 0, f2x_cnt = 0;
    logic [31:0] f2f_pend, div_pend, mult_pend, f2x_pend;

    always @(negedge clk) begin
        f2f_rdy = 1'b0;
        if (f2f_cnt > 0) begin
            f2f_cnt--;
            if (f2f_cnt == 0) begin f2f_rdy = 1'b1; f2f_result = f2f_pend; end
        end
        if (f2f_valid) begin f2f_cnt = LAT_F2F; f2f_pend = i2f(f2f_a); end
    end

    always @(negedge clk) begin
        div_rdy = 1'b0;
        if (div_cnt_ip > 0) begin
            div_cnt_ip--;
            if (div_cnt_ip == 0) begin div_rdy = 1'b1; div_result = div_pend; end
        end
        if (div_valid) begin div_cnt_ip = LAT_DIV; div_pend = fdiv(div_a, div_b); end
    end

    always @(negedge clk) begin
        mult_rdy = 1'b0;
        if (mult_cnt > 0) begin
            mult_cnt--;
            if (mult_cnt == 0) begin mult_rdy = 1'b1; mult_result = mult_pend; end
        end
        if (mult_valid) begin mult_cnt = LAT_MULT; mult_pend = fmul(mult_a, mult_b); end
        // Stray completion while the bin is still in its fixed2float step.
        if (inj_en && f2f_valid && int'(cdf_addr) == inj_bin) begin
            mult_rdy    = 1'b1;
            mult_result = 32'h4F00_0000;
        end
    end

    always @(negedge clk) begin
        f2x_rdy = 1'b0;
        if (f2x_cnt > 0) begin
            f2x_cnt--;
            if (f2x_cnt == 0) begin f2x_rdy = 1'b1; f2x_result = f2x_pend; end
        end
        if (f2x_valid) begin f2x_cnt = LAT_F2X; f2x_pend = forced(int'(cdf_addr), f2x(f2x_a)); end
    end

    // ---------------- compare process ----------------
    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (lut_we) begin
            chk("lut_addr", longint'(lut_addr), exp_bin);
            chk("lut_data", longint'(lut_data), longint'(exp_lut[lut_addr]));
            dut_lut[lut_addr] = int'(lut_data);
            exp_bin++;
            writes++;
        end
        if (done) begin
            done_cnt++;
            chk("busy_low_at_done", longint'(busy), 0);
        end
        if (div_valid) div_cnt++;
        if (f2f_valid)  chk("f2f_valid_width",  longint'(prev_f2f), 0);
        if (div_valid)  chk("div_valid_width",  longint'(prev_div), 0);
        if (mult_valid) chk("mult_valid_width", longint'(prev_mult), 0);
        if (f2x_valid)  chk("f2x_valid_width",  longint'(prev_f2x), 0);
        prev_f2f  = f2f_valid;
        prev_div  = div_valid;
        prev_mult = mult_valid;
        prev_f2x  = f2x_valid;
    endtask

    // Enters with reset asserted; leaves at the 16th negedge after release.
    task automatic flush_window();
        repeat (3) step();
        chk("rst_strobes", longint'({busy, done, cdf_rd_en, lut_we,
                                     f2f_valid, div_valid, mult_valid, f2x_valid}), 0);
        chk("rst_addr_data", longint'({cdf_addr, lut_addr, lut_data}), 0);
        chk("rst_operands", longint'(f2f_a | div_a | div_b | mult_a | mult_b | f2x_a), 0);
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
            if (k == 8 || k == 16) chk("start_in_flush_ignored", longint'(busy), 0);
        end
    endtask

    task automatic do_run(input logic [31:0] tp, input logic [31:0] mn,
                          input bit hold_rfd, input bit restart50, input bit abort100);
        int k;
        bit fin;
        build_model(tp, mn);
        exp_bin = 0; writes = 0; done_cnt = 0; div_cnt = 0;
        for (int i = 0; i < 256; i++) dut_lut[i] = -1;
        total_pixels = tp;
        cdf_min      = mn;
        start        = 1'b1;
        if (hold_rfd) f2f_rfd = 1'b0;
        k = 0;
        fin = 1'b0;
        while (!fin && k < 20000) begin
            step();
            k++;
            if (k == 1) begin
                start = 1'b0;
                chk("busy_after_start", longint'(busy), 1);
            end
            if (hold_rfd) begin
                if (k <= 6) chk("f2f_valid_while_rfd_low", longint'(f2f_valid), 0);
                if (k == 6) f2f_rfd = 1'b1;
                if (k == 7) chk("f2f_valid_after_rfd", longint'(f2f_valid), 1);
                if (k == 8) chk("f2f_valid_one_cycle", longint'(f2f_valid), 0);
            end
            if (restart50) start = (lut_we && lut_addr == 8'd50);
            if (abort100 && mult_valid && cdf_addr == 8'd100) begin
                reset = 1'b0;
                fin   = 1'b1;
            end
            if (done) fin = 1'b1;
        end
        start = 1'b0;
        chk("run_completed", longint'(fin), 1);
        if (!abort100) begin
            step();
            chk("done_one_cycle", longint'(done), 0);
            repeat (20) step();
            chk("write_count", writes, 256);
            chk("done_count", done_cnt, 1);
            chk("busy_after_done", longint'(busy), 0);
        end
    endtask

    int zeros;

    initial begin
        prev_f2f = 1'b0; prev_div = 1'b0; prev_mult = 1'b0; prev_f2x = 1'b0;
        exp_bin = 0; writes = 0; done_cnt = 0; div_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cdf[i]     = 32'(256 * (i + 1));
            exp_lut[i] = 8'd0;
            dut_lut[i] = -1;
        end
        reset = 1'b1;
        #2 reset = 1'b0;
        flush_window();

        // Linear CDF, fixed2float held not-ready at the start.
        do_run(32'd65536, 32'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++)
            chk("model_linear", longint'(exp_lut[i]),
                ((255 * (i + 1) + 128) / 256 > 255) ? 255 : (255 * (i + 1) + 128) / 256);
        chk("lin_lut0",   dut_lut[0],   1);
        chk("lin_lut63",  dut_lut[63],  64);
        chk("lin_lut127", dut_lut[127], 128);
        chk("lin_lut255", dut_lut[255], 255);
        chk("lin_one_div", div_cnt, 1);

        // total_pixels == cdf_min: no division, scale forced to zero.
        do_run(32'd100, 32'd100, 1'b0, 1'b0, 1'b0);
        zeros = 0;
        for (int i = 0; i < 256; i++) if (dut_lut[i] == 0) zeros++;
        chk("skip_all_zero", zeros, 256);
        chk("skip_no_div", div_cnt, 0);

        // Nonzero cdf_min, forced saturation, stray multiplier completion.
        cdf[0] = 32'd30;
        for (int i = 1; i < 256; i++) cdf[i] = 32'(40 + (i * 4960) / 255);
        force_en = 1'b1;
        inj_en   = 1'b1;
        do_run(32'd5000, 32'd40, 1'b0, 1'b0, 1'b0);
        chk("mdl_lut0",   longint'(exp_lut[0]),   0);
        chk("mdl_lut10",  longint'(exp_lut[10]),  0);
        chk("mdl_lut11",  longint'(exp_lut[11]),  255);
        chk("mdl_lut128", longint'(exp_lut[128]), 128);
        chk("mdl_lut255", longint'(exp_lut[255]), 255);
        chk("neg_clamp_lut10", dut_lut[10], 0);
        chk("sat_lut11",       dut_lut[11], 255);
        chk("lut255_full",     dut_lut[255], 255);
        force_en = 1'b0;
        inj_en   = 1'b0;

        // Abort at bin 100 in the multiply step, then a clean restart.
        for (int i = 0; i < 256; i++) cdf[i] = 32'(256 * (i + 1));
        do_run(32'd65536, 32'd0, 1'b0, 1'b0, 1'b1);
        flush_window();
        chk("no_write_after_abort", writes, 100);
        do_run(32'd65536, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("restart_lut50",  dut_lut[50],  51);
        chk("restart_lut100", dut_lut[100], 101);
        chk("restart_lut255", dut_lut[255], 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
